// File: rtl/credit_rr_switch_allocator_pkg.sv
// Purpose: shared sizing, matrix types and request helper for the credit-gated switch allocator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a; credit flow control is implemented in credit_rr_switch_allocator.
package credit_rr_switch_allocator_pkg;

    localparam int N                 = 5;   // router inputs
    localparam int M                 = 5;   // router outputs (0 = local PE)
    localparam int INPUT_QUEUE_DEPTH = 4;   // downstream input FIFO depth
    localparam int CREDIT_W          = $clog2(INPUT_QUEUE_DEPTH + 1);
    localparam int PTR_W             = (N > 1) ? $clog2(N) : 1;

    typedef logic [0:N-1][0:M-1] req_mat_t;    // [input][output]
    typedef logic [0:M-1][0:N-1] grant_mat_t;  // [output][input]

    // Keep only the lowest-index set bit; an input may target one output per cycle.
    function automatic logic [0:M-1] lowest_req(input logic [0:M-1] req);
        logic found;
        lowest_req = '0;
        found      = 1'b0;
        for (int m = 0; m < M; m++) begin
            if (req[m] && !found) begin
                lowest_req[m] = 1'b1;
                found         = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/credit_rr_switch_allocator_arbiter.sv
// Purpose: one N-way round-robin arbiter with its own priority pointer (one per output).
// Latency: grant is combinational from req/en; pointer advances on the clk edge after a grant.
// Backpressure: en low (no downstream credit) forces grant to zero and freezes the pointer.
// Ports: clk, reset_n (async active-low), en (eligibility), req[0:N-1], grant[0:N-1] one-hot.
module rr_arbiter_n
    import credit_rr_switch_allocator_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [0:N-1] req,
    output logic [0:N-1] grant
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan ptr, ptr+1, ... modulo N; first requester wins and the pointer moves past it.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_nxt    = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/credit_rr_switch_allocator.sv
// Purpose: per-router switch allocator, round-robin per output, gated by downstream credits.
// Latency: zero cycles request-to-grant; credits/pointers update on the following clk edge.
// Backpressure: an output with zero credits grants nobody; a returned credit helps next cycle.
// Ports: i_output_req[in][out] -> o_output_grant[out][in] one-hot, o_input_grant[in] FIFO pop;
//        i_credit_ret[out] pops downstream; o_credit_cnt[out] count; o_credit_err sticky overflow.
module credit_rr_switch_allocator
    import credit_rr_switch_allocator_pkg::*;
#(
    parameter int  CREDITS         = INPUT_QUEUE_DEPTH,
    parameter bit  LOCAL_UNLIMITED = 1'b1,
    localparam int CW              = $clog2(CREDITS + 1)
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [0:N-1][0:M-1]   i_output_req,
    input  logic [0:M-1]          i_credit_ret,
    output logic [0:M-1][0:N-1]   o_output_grant,
    output logic [0:N-1]          o_input_grant,
    output logic [0:M-1][CW-1:0]  o_credit_cnt,
    output logic                  o_credit_err
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [0:N-1][0:M-1] norm_req;
    logic [0:M-1][0:N-1] col_req;
    logic [0:M-1]        elig;
    logic [0:M-1]        granted;

    always_comb begin
        norm_req = '0;
        col_req  = '0;
        for (int i = 0; i < N; i++) begin
            norm_req[i] = lowest_req(i_output_req[i]);
        end
        for (int m = 0; m < M; m++) begin
            for (int i = 0; i < N; i++) begin
                col_req[m][i] = norm_req[i][m];
            end
        end
    end

    // Eligibility uses the registered count only, so a same-cycle return never bypasses.
    // reset_n gates it so requests cannot produce grants while reset is held.
    always_comb begin
        elig = '0;
        for (int m = 0; m < M; m++) begin
            elig[m] = reset_n && ((o_credit_cnt[m] != '0) || (m == 0 && LOCAL_UNLIMITED));
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_arb
        rr_arbiter_n u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (elig[m]),
            .req     (col_req[m]),
            .grant   (o_output_grant[m])
        );
        assign granted[m] = |o_output_grant[m];
    end

    always_comb begin
        o_input_grant = '0;
        for (int m = 0; m < M; m++) begin
            for (int i = 0; i < N; i++) begin
                o_input_grant[i] = o_input_grant[i] | o_output_grant[m][i];
            end
        end
    end

    // Grant and return together cancel; a return with no grant at full count saturates
    // and flags the error. Underflow cannot occur because a zero count is never eligible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_credit_cnt <= {M{CRED_MAX}};
            o_credit_err <= 1'b0;
        end else begin
            for (int m = 0; m < M; m++) begin
                if (m == 0 && LOCAL_UNLIMITED) begin
                    o_credit_cnt[m] <= CRED_MAX;
                end else if (granted[m] && !i_credit_ret[m]) begin
                    o_credit_cnt[m] <= o_credit_cnt[m] - 1'b1;
                end else if (!granted[m] && i_credit_ret[m]) begin
                    if (o_credit_cnt[m] == CRED_MAX) begin
                        o_credit_err <= 1'b1;
                    end else begin
                        o_credit_cnt[m] <= o_credit_cnt[m] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_credit_rr_switch_allocator.sv
// Purpose: scoreboard bench for credit_rr_switch_allocator against a queue/array reference model.
// Latency: expectations pushed #1 after each rising edge, compared on the following falling edge.
// Backpressure: n/a (bench drives requests and credit returns freely).
`timescale 1ns/1ps
module tb_credit_rr_switch_allocator;
    import credit_rr_switch_allocator_pkg::*;

    localparam int CREDITS         = INPUT_QUEUE_DEPTH;
    localparam bit LOCAL_UNLIMITED = 1'b1;
    localparam int CW              = CREDIT_W;

    typedef struct {
        logic [0:M-1][0:N-1]  og;
        logic [0:N-1]         ig;
        logic [0:M-1][CW-1:0] cnt;
        logic                 err;
        int                   step;
    } exp_t;

    logic                 clk;
    logic                 reset_n;
    logic [0:N-1][0:M-1]  i_output_req;
    logic [0:M-1]         i_credit_ret;
    logic [0:M-1][0:N-1]  o_output_grant;
    logic [0:N-1]         o_input_grant;
    logic [0:M-1][CW-1:0] o_credit_cnt;
    logic                 o_credit_err;

    credit_rr_switch_allocator #(
        .CREDITS         (CREDITS),
        .LOCAL_UNLIMITED (LOCAL_UNLIMITED)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_output_req   (i_output_req),
        .i_credit_ret   (i_credit_ret),
        .o_output_grant (o_output_grant),
        .o_input_grant  (o_input_grant),
        .o_credit_cnt   (o_credit_cnt),
        .o_credit_err   (o_credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_step = 0;

    // Reference state: next-to-serve input per output, free downstream slots, sticky error.
    int mptr[M];
    int mcnt[M];
    bit merr;

    function automatic void model_reset();
        for (int m = 0; m < M; m++) begin
            mptr[m] = 0;
            mcnt[m] = CREDITS;
        end
        merr = 1'b0;
    endfunction

    function automatic void model_step(input logic [0:N-1][0:M-1] req,
                                       input logic [0:M-1] ret,
                                       input bit in_reset,
                                       output exp_t e);
        int want[N];
        int winner;
        int cand;
        e.og   = '0;
        e.ig   = '0;
        e.err  = merr;
        e.step = n_step;
        for (int m = 0; m < M; m++) e.cnt[m] = CW'(mcnt[m]);
        if (in_reset) return;
        for (int i = 0; i < N; i++) begin
            want[i] = -1;
            for (int m = 0; m < M; m++)
                if (req[i][m] && want[i] < 0) want[i] = m;
        end
        for (int m = 0; m < M; m++) begin
            winner = -1;
            if (mcnt[m] > 0 || (m == 0 && LOCAL_UNLIMITED)) begin
                for (int k = 0; k < N; k++) begin
                    cand = (mptr[m] + k) % N;
                    if (winner < 0 && want[cand] == m) winner = cand;
                end
            end
            if (winner >= 0) begin
                e.og[m][winner] = 1'b1;
                e.ig[winner]    = 1'b1;
                mptr[m]         = (winner + 1) % N;
            end
            if (!(m == 0 && LOCAL_UNLIMITED)) begin
                mcnt[m] = mcnt[m] - ((winner >= 0) ? 1 : 0) + (ret[m] ? 1 : 0);
                if (mcnt[m] > CREDITS) begin
                    mcnt[m] = CREDITS;
                    merr    = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [0:N-1][0:M-1] req_one(input int i, input int m);
        req_one       = '0;
        req_one[i][m] = 1'b1;
    endfunction

    function automatic logic [0:M-1] ret_one(input int m);
        ret_one    = '0;
        ret_one[m] = 1'b1;
    endfunction

    task automatic drive(input logic [0:N-1][0:M-1] req, input logic [0:M-1] ret);
        exp_t e;
        @(posedge clk);
        #1;
        i_output_req = req;
        i_credit_ret = ret;
        model_step(req, ret, 1'b0, e);
        exp_q.push_back(e);
        n_step++;
    endtask

    // Asserts reset between edges with the current stimulus still applied, so the
    // expectation also covers grants collapsing immediately.
    task automatic pulse_reset();
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        model_step(i_output_req, i_credit_ret, 1'b1, e);
        exp_q.push_back(e);
        n_step++;
        @(negedge clk);
        #1;
        i_output_req = '0;
        i_credit_ret = '0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Monitor: pops one expectation per falling edge while any are pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (o_output_grant !== e.og) begin
                    n_bad++;
                    $display("FAIL output_grant step %0d: got %h want %h", e.step, o_output_grant, e.og);
                end
                n_cmp++;
                if (o_input_grant !== e.ig) begin
                    n_bad++;
                    $display("FAIL input_grant step %0d: got %h want %h", e.step, o_input_grant, e.ig);
                end
                n_cmp++;
                if (o_credit_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL credit_cnt step %0d: got %h want %h", e.step, o_credit_cnt, e.cnt);
                end
                n_cmp++;
                if (o_credit_err !== e.err) begin
                    n_bad++;
                    $display("FAIL credit_err step %0d: got %b want %b", e.step, o_credit_err, e.err);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:N-1][0:M-1] r;
        logic [0:M-1]        rt;
        logic [0:M-1]        row;

        reset_n      = 1'b0;
        i_output_req = '0;
        i_credit_ret = '0;
        model_reset();
        pulse_reset();

        // Single request: input 1 -> output 2, then observe the consumed credit.
        drive(req_one(1, 2), '0);
        drive('0, '0);

        // Four inputs contend for output 1 with a credit returned every cycle.
        r = req_one(0, 1) | req_one(1, 1) | req_one(3, 1) | req_one(4, 1);
        repeat (5) drive(r, ret_one(1));
        drive('0, '0);

        // Exhaust output 3, then one return: grant resumes only the cycle after it.
        repeat (6) drive(req_one(2, 3), '0);
        drive(req_one(2, 3), ret_one(3));
        repeat (2) drive(req_one(2, 3), '0);
        drive('0, '0);

        // Local output is unlimited; returns on it are ignored.
        for (int c = 0; c < 10; c++) drive(req_one(4, 0), (c % 3 == 0) ? ret_one(0) : '0);

        // Output 2 back to full, then an extra return overflows and latches the error.
        drive('0, ret_one(2));
        drive('0, ret_one(2));
        drive('0, '0);

        // Multi-bit request: only the lowest-index output (2) is used.
        r = '0;
        row = 5'b00110;
        r[0] = row;
        drive(r, '0);
        drive('0, '0);

        // Error clears on reset; then reset lands mid-burst with one credit left.
        pulse_reset();
        drive('0, '0);
        repeat (3) drive(req_one(2, 3), '0);
        pulse_reset();
        drive('0, '0);
        drive(req_one(1, 1) | req_one(3, 1), '0);
        drive(req_one(2, 3), '0);

        // Random traffic, occasionally reset.
        for (int c = 0; c < 300; c++) begin
            r = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) != 0) r[i] = M'($urandom);
            rt = '0;
            for (int m = 0; m < M; m++)
                rt[m] = ($urandom_range(0, 3) == 0);
            drive(r, rt);
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        drive('0, '0);

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
